// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// The slave side is the loader; the master side feeds bytes and observes IM writes.
interface imem_loader_if #(
    parameter int IM_AW = 7
) ();
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             im_we;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed, MSB-first byte image into the instruction memory
// and holds the CPU in reset until a complete image has been written.
module imem_loader #(
    parameter int IM_AW = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    imem_loader_if.slave     bus,
    output logic             cpu_rstn_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [IM_AW:0]   word_cnt_o
);
    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, BYTE, WRITE, DONE, ERR
    } state_t;

    localparam logic [16:0]    MAX_N    = 17'(2 ** IM_AW);
    localparam logic [IM_AW:0] CNT_ONE  = (IM_AW + 1)'(1);
    localparam logic [IM_AW-1:0] ADDR_ONE = IM_AW'(1);

    state_t           state_q;
    logic [7:0]       len_hi_q;
    logic [15:0]      len_q;
    logic [1:0]       idx_q;
    logic [31:0]      asm_q;
    logic [IM_AW-1:0] addr_q;
    logic             im_we_q;
    logic [IM_AW-1:0] im_addr_q;
    logic [31:0]      im_wdata_q;
    logic             cpu_rstn_q, busy_q, done_q, err_q;
    logic [IM_AW:0]   word_cnt_q;

    logic [15:0]    hdr_len_d;
    logic [31:0]    asm_d;
    logic [IM_AW:0] cnt_d;
    logic           take;
    logic           idle_like;

    assign hdr_len_d = {len_hi_q, bus.rx_data};
    assign asm_d     = {asm_q[23:0], bus.rx_data};
    assign cnt_d     = word_cnt_q + CNT_ONE;
    assign take      = bus.rx_valid && bus.rx_ready;
    assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);

    // Ready is a pure state decode so a source can see it without a cycle of lag.
    assign bus.rx_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            addr_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            case (state_q)
                HDR_HI: if (take) begin
                    len_hi_q <= bus.rx_data;
                    state_q  <= HDR_LO;
                end
                HDR_LO: if (take) begin
                    len_q <= hdr_len_d;
                    if (hdr_len_d == 16'd0 || {1'b0, hdr_len_d} > MAX_N) begin
                        state_q <= ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        idx_q   <= '0;
                        addr_q  <= '0;
                        state_q <= BYTE;
                    end
                end
                BYTE: if (take) begin
                    asm_q <= asm_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= addr_q;
                        im_wdata_q <= asm_d;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    im_we_q    <= 1'b0;
                    word_cnt_q <= cnt_d;
                    if ({{(15 - IM_AW){1'b0}}, cnt_d} == len_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q  <= addr_q + ADDR_ONE;
                        state_q <= BYTE;
                    end
                end
                DONE:    cpu_rstn_q <= 1'b1;
                default: ;
            endcase

            // A new session only starts from a quiescent state; later NBAs win.
            if (start_i && idle_like) begin
                state_q    <= HDR_HI;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                word_cnt_q <= '0;
                cpu_rstn_q <= 1'b0;
            end
        end
    end

    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_rstn_o   = cpu_rstn_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign word_cnt_o   = word_cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, stalled, restart-while-busy,
// bad-length, full-depth and reset-abort sessions.
module tb_imem_loader;
    localparam int IM_AW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_rstn, busy, done, err;
    logic [IM_AW:0] word_cnt;

    imem_loader_if #(.IM_AW(IM_AW)) bus ();

    imem_loader #(.IM_AW(IM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .bus        (bus),
        .cpu_rstn_o (cpu_rstn),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .word_cnt_o (word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] wbuf[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wa.push_back(32'(bus.im_addr));
            wd.push_back(bus.im_wdata);
        end
    end

    // Called at a negedge; returns at the negedge right after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        if (gap > 0) chk("rdy_stall", 32'(bus.rx_ready), 32'd1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic send_stream(input logic [15:0] n, input int gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        foreach (wbuf[i]) send_word(wbuf[i], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic new_session();
        wa.delete();
        wd.delete();
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        chk("cpu_held", 32'(cpu_rstn), 32'd0);
        chk("cnt_cleared", 32'(word_cnt), 32'd0);
    endtask

    // Entered at the negedge where the last WRITE is in progress.
    task automatic finish_ok(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rstn_lag"}, 32'(cpu_rstn), 32'd0);
        @(negedge clk);
        chk({tag, "_rstn"}, 32'(cpu_rstn), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cnt"}, 32'(word_cnt), 32'(wbuf.size()));
        chk({tag, "_nwr"}, 32'(wa.size()), 32'(wbuf.size()));
        foreach (wbuf[i]) begin
            if (i < wa.size()) begin
                chk({tag, "_addr"}, wa[i], 32'(i));
                chk({tag, "_data"}, wd[i], wbuf[i]);
            end
        end
        chk({tag, "_we_idle"}, 32'(bus.im_we), 32'd0);
        chk({tag, "_addr_hold"}, 32'(bus.im_addr), 32'(wbuf.size() - 1));
        chk({tag, "_data_hold"}, bus.im_wdata, wbuf[wbuf.size() - 1]);
    endtask

    task automatic expect_err(input string tag);
        @(negedge clk);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rstn"}, 32'(cpu_rstn), 32'd0);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2;
        chk("rst_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_we", 32'(bus.im_we), 32'd0);
        chk("rst_addr", 32'(bus.im_addr), 32'd0);
        chk("rst_wdata", bus.im_wdata, 32'd0);
        chk("rst_status", {28'd0, cpu_rstn, busy, done, err}, 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus.rx_ready), 32'd0);

        // Normal three-word image.
        wbuf = '{32'h20080005, 32'h20090007, 32'h01095020};
        new_session();
        send_stream(16'd3, 0);
        finish_ok("norm");

        // Restart from DONE, plus a stray start in the middle of a word.
        wbuf = '{32'hCAFEF00D, 32'h13579BDF};
        new_session();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        pulse_start();
        chk("busy_start_ignored", 32'(busy), 32'd1);
        send_byte(8'hF0, 0);
        send_byte(8'h0D, 0);
        send_word(32'h13579BDF, 0);
        finish_ok("midstart");

        // Three idle cycles before every byte.
        wbuf = '{32'hDEADBEEF, 32'h00112233};
        new_session();
        send_stream(16'd2, 3);
        finish_ok("stall");

        wbuf.delete();
        new_session();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        expect_err("zero");
        // Valid bytes offered while not ready must be left alone.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("err_ignore_rx", {31'd0, err}, 32'd1);
        chk("err_ignore_cnt", 32'(word_cnt), 32'd0);

        new_session();
        send_byte(8'h00, 0);
        send_byte(8'h81, 0);
        expect_err("over");

        // Full depth: 128 words.
        wbuf.delete();
        for (int i = 0; i < 128; i++) begin
            logic [7:0] b;
            b = 8'(i);
            wbuf.push_back({b, 8'h5A, ~b, b ^ 8'hC3});
        end
        new_session();
        send_stream(16'd128, 0);
        finish_ok("full");

        // Async reset after five bytes.
        new_session();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.rx_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rstn", 32'(cpu_rstn), 32'd0);
        chk("abort_addr", 32'(bus.im_addr), 32'd0);
        chk("abort_wdata", bus.im_wdata, 32'd0);
        chk("abort_nwr", 32'(wa.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        wbuf = '{32'h12345678};
        new_session();
        send_stream(16'd1, 0);
        finish_ok("after_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware counterpart of the bench-side instruction preload: receives a byte stream and writes 32-bit words into the sccomp instruction memory write port.
- Holds the CPU in reset (`cpu_rstn` low) while loading. Releases the CPU once the last word is written.
- Sits between a byte source (UART receiver or bench driver) and the IM/CPU reset inputs.

Parameters:
- IM_AW, 7, instruction memory word-address width; depth = 2^IM_AW words.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  IM write enable, one cycle per word.
- im_addr  output  IM_AW  IM word address.
- im_wdata  output  32  IM write data.
- cpu_rstn  output  1  active-low reset to sccomp; low while loading.
- busy  output  1  session in progress.
- done  output  1  sticky: last load completed OK.
- err  output  1  sticky: last load rejected.
- word_cnt  output  IM_AW+1  words written this session.

Behaviour:
- **Reset (async, rst=1):**
  - State goes to IDLE.
  - rx_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, word_cnt=0.
  - cpu_rstn=0, so the CPU is held in reset until a successful load.
- **Handshake:** a byte transfers on a rising clk edge when rx_valid && rx_ready. rx_ready is registered-free, decoded from state only.
- **Stream format:** 2-byte length N, MSB first, then N words. Each word is 4 bytes, MSB first (same order as the hex text used for preload). Words go to consecutive addresses starting at 0.
- **States:**
  - IDLE: rx_ready=0. start -> HDR_HI. Also clears done, err and word_cnt; sets busy=1 and cpu_rstn=0.
  - HDR_HI: rx_ready=1. On a byte, latch N[15:8] -> HDR_LO.
  - HDR_LO: rx_ready=1. On a byte, latch N[7:0].
    - If N==0 or N>2^IM_AW -> ERR.
    - Otherwise -> BYTE, with byte index=0 and address=0.
  - BYTE: rx_ready=1. Shift each byte into a 32-bit assembly register: {asm[23:0], rx_data}. After the 4th byte -> WRITE.
  - WRITE: rx_ready=0. im_we=1 for exactly one cycle, with im_addr = current address and im_wdata = the assembled word. word_cnt increments on this edge.
    - If word_cnt+1==N -> DONE.
    - Otherwise address+1 -> BYTE.
  - DONE: busy=0, done=1. cpu_rstn goes to 1 on the cycle after entering DONE (registered). start -> HDR_HI.
  - ERR: busy=0, err=1, cpu_rstn stays 0. start -> HDR_HI.
- **Latency and throughput:**
  - Minimum 5 cycles per word: 4 accept cycles + 1 WRITE cycle.
  - The first im_we is asserted 1 cycle after the 6th accepted byte.
- **Boundary conditions:**
  - start while busy is ignored.
  - rx_valid while rx_ready=0 is ignored; the byte is not consumed.
  - rx_valid gaps stall the FSM with no state change.
  - N == 2^IM_AW is legal. The last address is 2^IM_AW-1, and the address never wraps.
  - rst during a load aborts at once: cpu_rstn=0, and partially written IM contents are left as-is.
  - im_addr and im_wdata hold their last values when im_we=0.

Test Plan:
- **Normal 3-word load:** reset, start, bytes 00 03 20 08 00 05 | 20 09 00 07 | 01 09 50 20.
  - im_we pulses at addr 0,1,2 with data 0x20080005, 0x20090007, 0x01095020.
  - word_cnt=3, done=1, cpu_rstn rises 1 cycle after DONE, err=0.
- **Zero length:** bytes 00 00 -> err=1, done=0, cpu_rstn=0, no im_we.
- **Oversize length:** IM_AW=7, bytes 00 81 (N=129) -> err=1, no im_we. Bytes 00 80 (N=128) is accepted and im_addr reaches 0x7F.
- **Stalls:** rx_valid low for 3 cycles between every byte of a 2-word load.
  - Each word is still written once, with correct data.
  - rx_ready stays high while waiting.
- **start during busy:** pulse start mid-word.
  - No restart; the load completes normally.
  - A second start after DONE clears done, drives cpu_rstn=0 and accepts a new header.
- **Reset mid-load:** assert rst after 5 bytes.
  - All outputs return to reset values immediately (asynchronously).
  - After rst deasserts, a fresh start and full load succeeds.
